truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 247 ++++++++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
// Walks a 4-bit index through all 16 input combinations on a..d, waits
// SETTLE_CYCLES cycles at each one, then captures the 5-bit response y_i into
// a 16-entry table while folding it into a rotating signature and a ones
// count. An optional golden model counts captures that do not match the
// expected truth table.
//
// Optional feature macro: SWEEP_CMP_EN (golden comparison, mismatch_cnt/err).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a sweep (sampled only in IDLE)
//   abort             synchronous abort of a running sweep
//   a, b, c, d        registered drive, {a,b,c,d} = idx
//   y_i[4:0]          response from the logic under test
//   busy, done        status; done is a one-cycle completion pulse
//   rd_addr, rd_data  combinational table read port
//   signature         rotating XOR signature of all captures
//   ones_total        number of 1 bits captured in the sweep
//   mismatch_cnt, err golden-model mismatch count (saturating) and sticky flag
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic [4:0] y_i,
  output logic       busy,
  output logic       done,
  input  logic [3:0] rd_addr,
  output logic [4:0] rd_data,
  output logic [15:0] signature,
  output logic [6:0] ones_total,
  output logic [4:0] mismatch_cnt,
  output logic       err
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned ONES_W = 7;
  localparam int unsigned MM_W   = 5;
  localparam int unsigned DEPTH  = 16;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en;
  logic [Y_W-1:0]     mem_q [DEPTH];

  // Number of set bits in one response word.
  function automatic logic [2:0] popcount5(input logic [Y_W-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < int'(Y_W); i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

`ifdef SWEEP_CMP_EN
  logic [MM_W-1:0] mm_q, mm_d;
  logic            err_q, err_d;
  logic [Y_W-1:0]  gold_c;
  logic            ga, gb, gc, gd;

  // Expected response for the combination currently on a..d.
  always_comb begin
    ga = idx_q[3];
    gb = idx_q[2];
    gc = idx_q[1];
    gd = idx_q[0];
    gold_c[0] = (ga & gb) | (~gc & gd);
    gold_c[1] = ~(ga | gb | gc);
    gold_c[2] = (ga ^ gb) & (gc | gd);
    gold_c[3] = (ga & ~gb) | (gb & ~gc) | (gc & ~ga);
    gold_c[4] = (ga ^ gb) | ~(gc & gd);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over the settle/capture progression.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)                     state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort)                  state_d = S_IDLE;
        else if (idx_q == IDX_LAST) state_d = S_DONE;
        else                        state_d = S_SETTLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    sig_d  = sig_q;
    ones_d = ones_q;
    wr_en  = 1'b0;
`ifdef SWEEP_CMP_EN
    mm_d   = mm_q;
    err_d  = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d  = '0;
          cnt_d  = '0;
          sig_d  = '0;
          ones_d = '0;
`ifdef SWEEP_CMP_EN
          mm_d   = '0;
          err_d  = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (!abort) begin
          cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!abort) begin
          wr_en  = 1'b1;
          sig_d  = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(y_i);
          ones_d = ones_q + ONES_W'(popcount5(y_i));
`ifdef SWEEP_CMP_EN
          if (y_i != gold_c) begin
            err_d = 1'b1;
            if (mm_q != MM_W'(DEPTH)) mm_d = mm_q + 1'b1;
          end
`endif
          // idx stays at the last entry on completion so a..d hold it in IDLE.
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      sig_q  <= '0;
      ones_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      sig_q  <= sig_d;
      ones_q <= ones_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Response table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx_q] <= y_i;
    end
  end

`ifdef SWEEP_CMP_EN
  // Golden-compare statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_q  <= '0;
      err_q <= 1'b0;
    end else begin
      mm_q  <= mm_d;
      err_q <= err_d;
    end
  end

  assign mismatch_cnt = mm_q;
  assign err          = err_q;
`else
  assign mismatch_cnt = '0;
  assign err          = 1'b0;
`endif

  assign a          = idx_q[3];
  assign b          = idx_q[2];
  assign c          = idx_q[1];
  assign d          = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign ones_total = ones_q;
  assign rd_data    = mem_q[rd_addr];

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic        a, b, c, d;
  logic [4:0]  y;
  logic        busy, done;
  logic [3:0]  rd_addr;
  logic [4:0]  rd_data;
  logic [15:0] signature;
  logic [6:0]  ones_total;
  logic [4:0]  mismatch_cnt;
  logic        err;

  logic        start2, abort2;
  logic        a2, b2, c2, d2;
  logic [4:0]  y2;
  logic        busy2, done2;
  logic [3:0]  rd_addr2;
  logic [4:0]  rd_data2;
  logic [15:0] signature2;
  logic [6:0]  ones_total2;
  logic [4:0]  mismatch_cnt2;
  logic        err2;

  logic        ymode;   // 0: golden response, 1: response tied low

  int checks   = 0;
  int failures = 0;

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d), .y_i(y), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .signature(signature),
    .ones_total(ones_total), .mismatch_cnt(mismatch_cnt), .err(err)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .c(c2), .d(d2), .y_i(y2), .busy(busy2), .done(done2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .signature(signature2),
    .ones_total(ones_total2), .mismatch_cnt(mismatch_cnt2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gold(input logic [3:0] i);
    logic ga, gb, gc, gd;
    logic [4:0] g;
    ga = i[3]; gb = i[2]; gc = i[1]; gd = i[0];
    g[0] = (ga & gb) | (~gc & gd);
    g[1] = ~(ga | gb | gc);
    g[2] = (ga ^ gb) & (gc | gd);
    g[3] = (ga & ~gb) | (gb & ~gc) | (gc & ~ga);
    g[4] = (ga ^ gb) | ~(gc & gd);
    return g;
  endfunction

  // Downstream logic model driven by the sweeper outputs.
  always_comb begin
    y  = ymode ? 5'd0 : gold({a, b, c, d});
    y2 = ymode ? 5'd0 : gold({a2, b2, c2, d2});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges from the start edge until done is seen (bounded).
  task automatic wait_done(input int bound, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < bound) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(n), 32'(bound + 1));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_table_full(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #0.1;
      check($sformatf("%s_tbl%0d", tag, i), 32'(rd_data), 32'(gold(4'(i))));
    end
  endtask

  int          n;
  int          steps, bad, ndone;
  logic [3:0]  prev, cur;
  logic [15:0] exp_sig;
  logic [6:0]  exp_ones5;
  logic [4:0]  exp_mm_zero;
  logic        exp_err_zero;

  initial begin
`ifdef SWEEP_CMP_EN
    exp_mm_zero  = 5'd16;
    exp_err_zero = 1'b1;
`else
    exp_mm_zero  = 5'd0;
    exp_err_zero = 1'b0;
`endif
    exp_sig = 16'd0;
    for (int i = 0; i < 16; i++) exp_sig = {exp_sig[14:0], exp_sig[15]} ^ {11'b0, gold(4'(i))};
    exp_ones5 = 7'd0;
    for (int i = 0; i < 5; i++) exp_ones5 = exp_ones5 + 7'($countones(gold(4'(i))));

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_addr = 4'd0;
    start2 = 1'b0; abort2 = 1'b0; rd_addr2 = 4'd0; ymode = 1'b0;
    #12;
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abcd", 32'({a, b, c, d}), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    check("rst_ones", 32'(ones_total), 32'd0);
    check("rst_mm", 32'(mismatch_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tbl0", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Golden sweep
    pulse_start;
    check("g_busy", 32'(busy), 32'd1);
    check("g_abcd0", 32'({a, b, c, d}), 32'd0);
    wait_done(200, n);
    check("g_latency", 32'(n), 32'd32);
    check("g_abcd_end", 32'({a, b, c, d}), 32'hF);
    @(posedge clk); #1;
    check("g_done_pulse", 32'(done), 32'd0);
    check("g_idle", 32'(busy), 32'd0);
    check("g_hold_abcd", 32'({a, b, c, d}), 32'hF);
    check("g_ones", 32'(ones_total), 32'd41);
    check("g_sig", 32'(signature), 32'(exp_sig));
    check("g_mm", 32'(mismatch_cnt), 32'd0);
    check("g_err", 32'(err), 32'd0);
    rd_addr = 4'd0;  #0.1; check("g_tbl0_const", 32'(rd_data), 32'h12);
    rd_addr = 4'd15; #0.1; check("g_tbl15_const", 32'(rd_data), 32'h01);
    check_table_full("g");

    // Response tied low
    ymode = 1'b1;
    @(posedge clk); #1;
    pulse_start;
    wait_done(200, n);
    check("z_latency", 32'(n), 32'd32);
    @(posedge clk); #1;
    check("z_sig", 32'(signature), 32'd0);
    check("z_ones", 32'(ones_total), 32'd0);
    check("z_mm", 32'(mismatch_cnt), 32'(exp_mm_zero));
    check("z_err", 32'(err), 32'(exp_err_zero));
    rd_addr = 4'd0; #0.1; check("z_tbl0", 32'(rd_data), 32'd0);

    // Abort in the capture cycle of idx 5 (capture of idx i is 2*i+1 edges after start)
    ymode = 1'b0;
    @(posedge clk); #1;
    pulse_start;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
    end
    check("ab_abcd5", 32'({a, b, c, d}), 32'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ab_no_done", 32'(ndone), 32'd0);
    check("ab_abcd_hold", 32'({a, b, c, d}), 32'd5);
    check("ab_ones", 32'(ones_total), 32'(exp_ones5));
    for (int i = 0; i < 5; i++) begin
      rd_addr = 4'(i); #0.1;
      check($sformatf("ab_tbl%0d", i), 32'(rd_data), 32'(gold(4'(i))));
    end
    rd_addr = 4'd5; #0.1; check("ab_tbl5_kept", 32'(rd_data), 32'd0);
    rd_addr = 4'd6; #0.1; check("ab_tbl6_kept", 32'(rd_data), 32'd0);

    // Start held high: one sweep per IDLE visit, stats re-cleared
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(200, n);
    check("h_latency1", 32'(n), 32'd32);
    @(posedge clk); #1;
    check("h_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("h_restart", 32'(busy), 32'd1);
    wait_done(200, n);
    check("h_latency2", 32'(n), 32'd32);
    start = 1'b0;
    @(posedge clk); #1;
    check("h_idle", 32'(busy), 32'd0);
    check("h_ones", 32'(ones_total), 32'd41);
    check("h_sig", 32'(signature), 32'(exp_sig));
    check_table_full("h");

    // Asynchronous reset mid-sweep at idx 9
    pulse_start;
    n = 0;
    while ({a, b, c, d} != 4'd9 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("r_reach9", 32'({a, b, c, d}), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_abcd", 32'({a, b, c, d}), 32'd0);
    check("r_sig", 32'(signature), 32'd0);
    check("r_ones", 32'(ones_total), 32'd0);
    rd_addr = 4'd3; #0.1; check("r_tbl3", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("r_still_idle", 32'(busy), 32'd0);
    pulse_start;
    check("r_abcd0", 32'({a, b, c, d}), 32'd0);
    wait_done(200, n);
    check("r_latency", 32'(n), 32'd32);
    @(posedge clk); #1;
    check("r_ones", 32'(ones_total), 32'd41);
    check_table_full("r");

    // SETTLE_CYCLES = 15: a..d step once every 16 cycles, done after 256
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("s_abcd0", 32'({a2, b2, c2, d2}), 32'd0);
    prev = 4'd0; steps = 0; bad = 0; n = 0;
    while (!done2 && n < 600) begin
      @(posedge clk); #1;
      n++;
      cur = {a2, b2, c2, d2};
      if (cur != prev) begin
        steps++;
        if ((n % 16) != 0 || cur != prev + 4'd1) bad++;
      end
      prev = cur;
    end
    check("s_latency", 32'(n), 32'd256);
    check("s_steps", 32'(steps), 32'd15);
    check("s_bad_steps", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("s_done_pulse", 32'(done2), 32'd0);
    check("s_ones", 32'(ones_total2), 32'd41);
    check("s_sig", 32'(signature2), 32'(exp_sig));
    rd_addr2 = 4'd15; #0.1; check("s_tbl15", 32'(rd_data2), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
